// File: rtl/stream_dwc_upsizer.sv
// Packs RATIO = OUT_WIDTH/IN_WIDTH narrow stream beats, LSB-first, into one registered wide beat.
// Optional macro DWC_TLAST_EN adds out_V_V_TLAST, which marks the last word of each WORDS_PER_FRAME-word frame.
module stream_dwc_upsizer #(
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 32,
    parameter int WORDS_PER_FRAME = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
    input  logic                 in0_V_V_TVALID,
    output logic                 in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
    output logic                 out_V_V_TVALID,
`ifdef DWC_TLAST_EN
    output logic                 out_V_V_TLAST,
`endif
    input  logic                 out_V_V_TREADY
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int ACC_W = ((RATIO > 1) ? (RATIO - 1) : 1) * IN_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    generate
        if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("stream_dwc_upsizer: OUT_WIDTH must be an integer multiple (>= 2) of IN_WIDTH");
        end
        if (WORDS_PER_FRAME < 1) begin : g_bad_wpf
            $error("stream_dwc_upsizer: WORDS_PER_FRAME must be >= 1");
        end
    endgenerate

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [OUT_WIDTH-1:0] obuf_q, obuf_d;
    logic                 ovalid_q, ovalid_d;

    logic idx_last;
    logic in_accept;
    logic out_take;
    logic word_load;

    // Only the completing beat can be blocked; partial beats keep flowing while obuf stalls.
    assign idx_last       = (idx_q == IDX_LAST);
    assign in0_V_V_TREADY = !idx_last || !ovalid_q || out_V_V_TREADY;
    assign in_accept      = in0_V_V_TVALID && in0_V_V_TREADY;
    assign out_take       = ovalid_q && out_V_V_TREADY;
    assign word_load      = in_accept && idx_last;

    assign out_V_V_TDATA  = obuf_q;
    assign out_V_V_TVALID = ovalid_q;

    always_comb begin
        idx_d    = idx_q;
        acc_d    = acc_q;
        obuf_d   = obuf_q;
        ovalid_d = ovalid_q;

        if (out_take) begin
            ovalid_d = 1'b0;
        end

        if (in_accept) begin
            if (idx_last) begin
                obuf_d   = {in0_V_V_TDATA, acc_q};
                ovalid_d = 1'b1;
                idx_d    = '0;
            end else begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        acc_d[k*IN_WIDTH +: IN_WIDTH] = in0_V_V_TDATA;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            idx_q    <= '0;
            acc_q    <= '0;
            obuf_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            obuf_q   <= obuf_d;
            ovalid_q <= ovalid_d;
        end
    end

`ifdef DWC_TLAST_EN
    localparam int WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_FRAME - 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              tlast_q, tlast_d;

    // TLAST travels with obuf, so it is loaded, held and dropped together with the data word.
    always_comb begin
        wcnt_d  = wcnt_q;
        tlast_d = tlast_q;
        if (out_take) begin
            tlast_d = 1'b0;
        end
        if (word_load) begin
            tlast_d = (wcnt_q == WCNT_LAST);
            wcnt_d  = (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wcnt_q  <= '0;
            tlast_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            tlast_q <= tlast_d;
        end
    end

    assign out_V_V_TLAST = tlast_q;
`else
    logic unused_load;
    assign unused_load = word_load;
`endif

endmodule

// File: tb/tb_stream_dwc_upsizer.sv
// Directed and randomized checks for stream_dwc_upsizer with 8-bit in, 32-bit out.
// The TLAST scenario is compiled in only when DWC_TLAST_EN is defined.
module tb_stream_dwc_upsizer;

    localparam int WPF = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef DWC_TLAST_EN
    logic        out_last;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_ready;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;

    stream_dwc_upsizer #(
        .IN_WIDTH        (8),
        .OUT_WIDTH       (32),
        .WORDS_PER_FRAME (WPF)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .in0_V_V_TDATA  (in_data),
        .in0_V_V_TVALID (in_valid),
        .in0_V_V_TREADY (in_ready),
        .out_V_V_TDATA  (out_data),
        .out_V_V_TVALID (out_valid),
`ifdef DWC_TLAST_EN
        .out_V_V_TLAST  (out_last),
`endif
        .out_V_V_TREADY (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: drive on the falling edge, sample 1 time unit later, return after the rising edge.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
        @(negedge ap_clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        s_ready = in_ready;
        s_valid = out_valid;
        s_data  = out_data;
`ifdef DWC_TLAST_EN
        s_last  = out_last;
`else
        s_last  = 1'b0;
`endif
        @(posedge ap_clk);
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge ap_clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tvalid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_tdata: got %h want 00000000", out_data);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 8'h11, 1'b1);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_ready: got %b want 1", s_ready);
        end
        drive_cycle(1'b1, 8'h22, 1'b1);
        drive_cycle(1'b1, 8'h33, 1'b1);
        drive_cycle(1'b1, 8'h44, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early_valid: got %b want 0", s_valid);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_valid: got %b want 1", s_valid);
        end
        n_cmp++;
        if (s_data !== 32'h44332211) begin
            n_bad++;
            $display("FAIL basic_data: got %h want 44332211", s_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_valid_drop: got %b want 0", s_valid);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] e;
        w = 0;
        for (int c = 0; c < 42; c++) begin
            drive_cycle(c < 40, (c < 40) ? 8'(c) : 8'h00, 1'b1);
            if (c < 40) begin
                n_cmp++;
                if (s_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready c=%0d: got %b want 1", c, s_ready);
                end
            end
            if (s_valid === 1'b1) begin
                e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                n_cmp++;
                if (s_data !== e) begin
                    n_bad++;
                    $display("FAIL b2b_data w=%0d: got %h want %h", w, s_data, e);
                end
                n_cmp++;
                if (c !== 4*w + 4) begin
                    n_bad++;
                    $display("FAIL b2b_timing w=%0d: got cycle %0d want %0d", w, c, 4*w+4);
                end
                w++;
            end
        end
        n_cmp++;
        if (w !== 10) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 10", w);
        end
    endtask

    task automatic test_stall();
        logic [7:0] nxt;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h50 + i), 1'b0);
        nxt = 8'h60;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, nxt, 1'b0);
            n_cmp++;
            if (s_valid !== 1'b1 || s_data !== 32'h53525150) begin
                n_bad++;
                $display("FAIL stall_hold i=%0d: got %b/%h want 1/53525150", i, s_valid, s_data);
            end
            n_cmp++;
            if (s_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL stall_ready i=%0d: got %b want %b", i, s_ready, (i < 3));
            end
            if (s_ready === 1'b1) nxt = nxt + 8'h01;
        end
        drive_cycle(1'b1, nxt, 1'b1);
        n_cmp++;
        if (s_ready !== 1'b1 || s_valid !== 1'b1 || s_data !== 32'h53525150) begin
            n_bad++;
            $display("FAIL stall_release: got rdy=%b vld=%b %h want 1/1/53525150", s_ready, s_valid, s_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (s_valid !== 1'b1 || s_data !== 32'h63626160) begin
            n_bad++;
            $display("FAIL stall_next_word: got %b/%h want 1/63626160", s_valid, s_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drain: got %b want 0", s_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        drive_cycle(1'b1, 8'hB0, 1'b0);
        drive_cycle(1'b1, 8'hB1, 1'b0);
        n_cmp++;
        if (s_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pending: got %b want 1", s_valid);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b/%h want 0/00000000", out_valid, out_data);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'hA0 + i), 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (s_valid !== 1'b1 || s_data !== 32'hA3A2A1A0) begin
            n_bad++;
            $display("FAIL rstmid_word: got %b/%h want 1/a3a2a1a0", s_valid, s_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] part;
        logic [31:0] prev_data;
        logic [31:0] e;
        logic [7:0]  cur;
        logic        prev_stall;
        logic        v;
        logic        r;
        logic        exp_rdy;
        int nb;
        int cyc;
        int words;
        nb = 0; cyc = 0; words = 0;
        part = '0; prev_data = '0; prev_stall = 1'b0;
        cur = 8'($urandom);
        while (nb < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            drive_cycle(v, cur, r);
            cyc++;
            exp_rdy = ((nb % 4) != 3) || (q.size() == 0) || r;
            n_cmp++;
            if (s_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, s_ready, exp_rdy);
            end
            n_cmp++;
            if (s_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, s_valid, (q.size() != 0));
            end
            if (prev_stall) begin
                n_cmp++;
                if (s_data !== prev_data) begin
                    n_bad++;
                    $display("FAIL rand_stable cyc=%0d: got %h want %h", cyc, s_data, prev_data);
                end
            end
            if (s_valid === 1'b1 && r) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra_word cyc=%0d: got %h want none", cyc, s_data);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (s_data !== e) begin
                        n_bad++;
                        $display("FAIL rand_data w=%0d: got %h want %h", words, s_data, e);
                    end
                end
                words++;
            end
            if (v && s_ready === 1'b1) begin
                part[(nb % 4)*8 +: 8] = cur;
                nb++;
                if ((nb % 4) == 0) q.push_back(part);
                cur = 8'($urandom);
            end
            prev_stall = (s_valid === 1'b1) && !r;
            prev_data  = s_data;
        end
        if (nb < 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand_timeout: got %0d beats want 1000", nb);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1);
            if (s_valid === 1'b1) begin
                e = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
                n_cmp++;
                if (s_data !== e) begin
                    n_bad++;
                    $display("FAIL rand_drain: got %h want %h", s_data, e);
                end
                words++;
            end
        end
        n_cmp++;
        if (words !== 250 || q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_count: got %0d words (%0d left) want 250 (0 left)", words, q.size());
        end
    endtask

`ifdef DWC_TLAST_EN
    task automatic test_tlast();
        logic prev_stall;
        logic prev_last;
        logic r;
        logic exp_last;
        int nb;
        int w;
        int cyc;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        nb = 0; w = 0; cyc = 0;
        prev_stall = 1'b0; prev_last = 1'b0;
        while ((nb < 36 || w < 12) && cyc < 400) begin
            r = ((cyc % 3) != 0);
            drive_cycle(nb < 36, 8'(nb), r);
            cyc++;
            if (prev_stall) begin
                n_cmp++;
                if (s_last !== prev_last) begin
                    n_bad++;
                    $display("FAIL tlast_stable cyc=%0d: got %b want %b", cyc, s_last, prev_last);
                end
            end
            if (s_valid === 1'b1 && r) begin
                exp_last = ((w % WPF) == WPF - 1);
                n_cmp++;
                if (s_last !== exp_last) begin
                    n_bad++;
                    $display("FAIL tlast_word w=%0d: got %b want %b", w, s_last, exp_last);
                end
                w++;
            end
            if (nb < 36 && s_ready === 1'b1) nb++;
            prev_stall = (s_valid === 1'b1) && !r;
            prev_last  = s_last;
        end
        n_cmp++;
        if (w !== 12) begin
            n_bad++;
            $display("FAIL tlast_count: got %0d want 12", w);
        end
    endtask
`endif

    initial begin
        s_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef DWC_TLAST_EN
        test_tlast();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
